msg_to_pkt_queue: RTL and testbench
===================================

Name: msg_to_pkt_queue

Overview:
- Queue of the MESSAGE2PACKET stage, the reverse path of the NIC.
- Acts as a WISHBONE slave: it accepts write bursts (messages) from the bus and assembles each burst into a packet of flits (one bus beat = one flit).
- Stores complete packets in a circular FIFO and offers them to the output flit buffer through a request/grant handshake.

Parameters:
FLIT_WIDTH, 32, flit width; equals the bus data width
MAX_PACKET_LENGHT, 5, maximum flits per packet (head + data)
QUEUE_WIDTH, 4, number of packet slots
N_BITS_POINTER, 2, width of head/tail pointers (>= clog2(QUEUE_WIDTH))
N_BITS_COUNT, 3, width of the beat counter (>= clog2(MAX_PACKET_LENGHT+1))

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
wb_cyc_i  in  1  WISHBONE CYC; one message = one CYC assertion
wb_stb_i  in  1  WISHBONE STB
wb_we_i  in  1  WISHBONE WE; only writes are accepted
wb_dat_i  in  FLIT_WIDTH  beat data
wb_ack_o  out  1  beat accepted
wb_rty_o  out  1  no free slot, retry the message
wb_err_o  out  1  read attempt or over-length message
out_link_o  out  MAX_PACKET_LENGHT*FLIT_WIDTH  head-slot packet; flit 0 (LSBs) is the head
out_sel_o  out  MAX_PACKET_LENGHT  bit i high = flit i valid
r_msg_to_pkt_o  out  1  packet available (request to output buffer)
g_msg_to_pkt_i  in  1  grant; packet consumed this cycle

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM to IDLE; all valid bits, head/tail pointers and beat counter cleared to 0.
  - Slot data and sel cleared to 0, so out_link_o=0, out_sel_o=0, r_msg_to_pkt_o=0.
  - A message in progress is lost. The wb_* outputs are combinational and are 0 while no strobe is present.
- Beat qualifier: beat = wb_cyc_i & wb_stb_i. All wb_*_o outputs are combinational from the FSM state, beat, wb_we_i, valid[tail] and the counter. At most one of ack/rty/err is high.
- FSM states: IDLE, COLLECT, DISCARD.
  - IDLE, beat & !wb_we_i: err=1; stay in IDLE.
  - IDLE, beat & wb_we_i & valid[tail]=1 (queue full): rty=1; stay in IDLE; nothing stored.
  - IDLE, beat & wb_we_i & valid[tail]=0:
    - ack=1; flit0 of slot[tail] <= wb_dat_i; sel[tail] <= 'b1.
    - Flits 1..MAX-1 of the slot <= 0; count <= 1; go to COLLECT.
  - COLLECT, beat & wb_we_i & count<MAX_PACKET_LENGHT: ack=1; flit[count] <= wb_dat_i; sel[tail][count] <= 1; count <= count+1.
  - COLLECT, beat & (!wb_we_i | count==MAX_PACKET_LENGHT): err=1; go to DISCARD.
  - COLLECT, wb_cyc_i=0 (commit): valid[tail] <= 1; tail <= tail+1, wrapping at QUEUE_WIDTH-1 to 0; count <= 0; go to IDLE.
  - DISCARD: err=1 on every beat. On wb_cyc_i=0: go to IDLE; valid and tail unchanged; sel[tail] <= 0.
- Slot reservation: the tail slot is checked free only on the first beat. The slot cannot be filled by anything else while the FSM is in COLLECT.
- Output side:
  - r_msg_to_pkt_o = valid[head]; out_link_o/out_sel_o = slot[head], all combinational.
  - Pop when r_msg_to_pkt_o & g_msg_to_pkt_i: valid[head] <= 0; head <= head+1 with wrap.
  - Grant while the request is low is ignored.
- Simultaneous commit (tail) and pop (head) in one cycle: both take effect. They always address distinct slots, because a committing slot is invalid until this edge.
- Latency: the committed packet appears on r_msg_to_pkt_o in the cycle after the CYC-low cycle. The queue is full after QUEUE_WIDTH commits without pops.
- Zero-beat CYC (CYC without STB): no effect.

Test Plan:
- Reset: assert rst=0 mid-COLLECT after 2 beats -> immediately r_msg_to_pkt_o=0, out_sel_o=0; after release a new message is stored in slot 0.
- Single-beat write 0xA5A5_0001, then CYC low -> ack for 1 cycle; next cycle r_msg_to_pkt_o=1, out_sel_o=5'b00001, out_link_o[31:0]=0xA5A5_0001, upper flits 0. Grant pulse -> request drops the following cycle.
- 5-beat burst 0x10..0x14 -> five acks; out_sel_o=5'b11111; flit i = 0x10+i.
- 6-beat burst -> beats 1-5 acked, beat 6 err=1; after CYC low no request; the next 2-beat message gives out_sel_o=5'b00011 from the same slot.
- Fill 4 slots with no grant -> the 5th message's first beat gets rty=1 and no ack. Grant once -> retry succeeds; tail wraps 3->0.
- Read beat (we=0) in IDLE -> err=1, queue unchanged. Commit and grant in the same cycle with 2 queued -> count stays 2, order preserved.

Source files
------------

// File: rtl/msg_to_pkt_queue.sv
// msg_to_pkt_queue: reverse-path MESSAGE2PACKET queue of the NIC.
// Takes WISHBONE write bursts (one beat = one flit) and assembles each burst
// into a packet in a circular set of slots. Complete packets are offered to
// the output flit buffer through a request/grant handshake.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   wb_cyc_i/stb_i/we_i      WISHBONE slave controls, one message per CYC
//   wb_dat_i                 beat data (one flit)
//   wb_ack_o/rty_o/err_o     beat accepted / no free slot / read or too long
//   out_link_o, out_sel_o    head-slot packet and its flit-valid mask
//   r_msg_to_pkt_o           packet available at head
//   g_msg_to_pkt_i           grant, head packet consumed this cycle
//
// state   | meaning
// IDLE    | waiting for the first beat of a message
// COLLECT | tail slot reserved, appending flits until CYC drops
// DISCARD | message rejected, erroring beats until CYC drops
module msg_to_pkt_queue #(
  parameter int FLIT_WIDTH        = 32,
  parameter int MAX_PACKET_LENGHT = 5,
  parameter int QUEUE_WIDTH       = 4,
  parameter int N_BITS_POINTER    = 2,
  parameter int N_BITS_COUNT      = 3
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wb_cyc_i,
  input  logic                                    wb_stb_i,
  input  logic                                    wb_we_i,
  input  logic [FLIT_WIDTH-1:0]                   wb_dat_i,
  output logic                                    wb_ack_o,
  output logic                                    wb_rty_o,
  output logic                                    wb_err_o,
  output logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] out_link_o,
  output logic [MAX_PACKET_LENGHT-1:0]            out_sel_o,
  output logic                                    r_msg_to_pkt_o,
  input  logic                                    g_msg_to_pkt_i
);

  localparam int MAX = MAX_PACKET_LENGHT;
  localparam int FW  = FLIT_WIDTH;

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

  state_t                    state_q, state_d;
  logic [MAX*FW-1:0]         data_q [QUEUE_WIDTH];
  logic [MAX-1:0]            sel_q  [QUEUE_WIDTH];
  logic [QUEUE_WIDTH-1:0]    valid_q;
  logic [N_BITS_POINTER-1:0] head_q, tail_q;
  logic [N_BITS_COUNT-1:0]   count_q;

  logic beat;
  logic start, append, commit, drop, pop;

  function automatic logic [N_BITS_POINTER-1:0] ptr_inc(input logic [N_BITS_POINTER-1:0] p);
    return (p == N_BITS_POINTER'(QUEUE_WIDTH-1)) ? '0 : p + N_BITS_POINTER'(1);
  endfunction

  assign beat = wb_cyc_i & wb_stb_i;
  assign pop  = valid_q[head_q] & g_msg_to_pkt_i;

  always_comb begin
    state_d  = state_q;
    wb_ack_o = 1'b0;
    wb_rty_o = 1'b0;
    wb_err_o = 1'b0;
    start    = 1'b0;
    append   = 1'b0;
    commit   = 1'b0;
    drop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (!wb_we_i) begin
            wb_err_o = 1'b1;
          end else if (valid_q[tail_q]) begin
            wb_rty_o = 1'b1;
          end else begin
            wb_ack_o = 1'b1;
            start    = 1'b1;
            state_d  = COLLECT;
          end
        end
      end
      COLLECT: begin
        if (!wb_cyc_i) begin
          commit  = 1'b1;
          state_d = IDLE;
        end else if (beat) begin
          if (wb_we_i && (count_q < N_BITS_COUNT'(MAX))) begin
            wb_ack_o = 1'b1;
            append   = 1'b1;
          end else begin
            wb_err_o = 1'b1;
            state_d  = DISCARD;
          end
        end
      end
      DISCARD: begin
        if (beat) wb_err_o = 1'b1;
        if (!wb_cyc_i) begin
          drop    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int s = 0; s < QUEUE_WIDTH; s++) begin
        data_q[s] <= '0;
        sel_q[s]  <= '0;
      end
    end else begin
      state_q <= state_d;
      if (start) begin
        // First beat also clears stale flits left by an earlier packet.
        data_q[tail_q] <= (MAX*FW)'(wb_dat_i);
        sel_q[tail_q]  <= MAX'(1);
        count_q        <= N_BITS_COUNT'(1);
      end
      if (append) begin
        for (int f = 0; f < MAX; f++) begin
          if (count_q == N_BITS_COUNT'(f)) begin
            data_q[tail_q][f*FW +: FW] <= wb_dat_i;
            sel_q[tail_q][f]           <= 1'b1;
          end
        end
        count_q <= count_q + N_BITS_COUNT'(1);
      end
      if (commit) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= ptr_inc(tail_q);
        count_q         <= '0;
      end
      if (drop) begin
        sel_q[tail_q] <= '0;
        count_q       <= '0;
      end
      // A committing slot is never the valid head, so both writes can coexist.
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= ptr_inc(head_q);
      end
    end
  end

  assign r_msg_to_pkt_o = valid_q[head_q];
  assign out_link_o     = data_q[head_q];
  assign out_sel_o      = sel_q[head_q];

endmodule

// File: tb/tb_msg_to_pkt_queue.sv
module tb_msg_to_pkt_queue;
  localparam int FW   = 32;
  localparam int MAXP = 5;
  localparam int QW   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cyc, stb, we, gnt;
  logic [FW-1:0]     dat;
  logic              ack, rty, err, req;
  logic [MAXP*FW-1:0] link;
  logic [MAXP-1:0]   sel;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [MAXP*FW-1:0] link;
    logic [MAXP-1:0]    sel;
  } pkt_t;

  pkt_t               mq[$];
  int                 mstate;   // 0: no message, 1: building, 2: dropping
  logic [MAXP*FW-1:0] cur_link;
  int                 cur_n;

  msg_to_pkt_queue dut (
    .clk(clk), .rst(rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_dat_i(dat),
    .wb_ack_o(ack), .wb_rty_o(rty), .wb_err_o(err),
    .out_link_o(link), .out_sel_o(sel),
    .r_msg_to_pkt_o(req), .g_msg_to_pkt_i(gnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mq.delete();
    mstate   = 0;
    cur_n    = 0;
    cur_link = '0;
  endtask

  // Called at posedge+1; drives one cycle, checks it, advances model, returns at next posedge+1.
  task automatic do_cycle(input logic c, input logic s, input logic w,
                          input logic [FW-1:0] d, input logic g);
    logic e_ack, e_rty, e_err, e_req, bt;
    bit   st, ap, cm, tod, toi;
    cyc = c; stb = s; we = w; dat = d; gnt = g;
    #1;
    bt = c & s;
    e_ack = 0; e_rty = 0; e_err = 0;
    st = 0; ap = 0; cm = 0; tod = 0; toi = 0;
    e_req = (mq.size() > 0);
    case (mstate)
      0: if (bt) begin
           if (!w) e_err = 1;
           else if (mq.size() == QW) e_rty = 1;
           else begin e_ack = 1; st = 1; end
         end
      1: if (!c) cm = 1;
         else if (bt) begin
           if (w && cur_n < MAXP) begin e_ack = 1; ap = 1; end
           else begin e_err = 1; tod = 1; end
         end
      default: begin
        if (bt) e_err = 1;
        if (!c) toi = 1;
      end
    endcase
    total++; if (ack !== e_ack) begin bad++; $display("FAIL ack t=%0t: got %b want %b", $time, ack, e_ack); end
    total++; if (rty !== e_rty) begin bad++; $display("FAIL rty t=%0t: got %b want %b", $time, rty, e_rty); end
    total++; if (err !== e_err) begin bad++; $display("FAIL err t=%0t: got %b want %b", $time, err, e_err); end
    total++; if (req !== e_req) begin bad++; $display("FAIL req t=%0t: got %b want %b", $time, req, e_req); end
    if (e_req) begin
      total++; if (sel !== mq[0].sel) begin bad++; $display("FAIL sel t=%0t: got %b want %b", $time, sel, mq[0].sel); end
      total++; if (link !== mq[0].link) begin bad++; $display("FAIL link t=%0t: got %h want %h", $time, link, mq[0].link); end
    end
    if (e_req && g) void'(mq.pop_front());
    if (st) begin cur_link = '0; cur_link[FW-1:0] = d; cur_n = 1; mstate = 1; end
    if (ap) begin cur_link[cur_n*FW +: FW] = d; cur_n++; end
    if (cm) begin
      mq.push_back('{link: cur_link, sel: MAXP'((1 << cur_n) - 1)});
      mstate = 0;
    end
    if (tod) mstate = 2;
    if (toi) mstate = 0;
    @(posedge clk); #1;
  endtask

  task automatic send_msg(input int n, input logic [FW-1:0] base, input logic g_last);
    for (int i = 0; i < n; i++) do_cycle(1, 1, 1, base + FW'(i), 0);
    do_cycle(0, 0, 0, '0, g_last);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && mq.size() > 0; i++) do_cycle(0, 0, 0, '0, 1);
  endtask

  task automatic test_reset();
    rst = 0; cyc = 0; stb = 0; we = 0; dat = '0; gnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", req); end
    total++; if (sel !== '0) begin bad++; $display("FAIL reset_sel: got %b want 0", sel); end
    total++; if (link !== '0) begin bad++; $display("FAIL reset_link: got %h want 0", link); end
    total++; if ({ack, rty, err} !== 3'b000) begin bad++; $display("FAIL reset_wb: got %b want 000", {ack, rty, err}); end
    rst = 1;
    @(posedge clk); #1;
    send_msg(1, 32'hDEAD_0001, 0);
    do_cycle(1, 1, 1, 32'h0000_1111, 0);
    do_cycle(1, 1, 1, 32'h0000_2222, 0);
    // async reset mid-COLLECT with the strobe idle
    stb = 0;
    #1 rst = 0;
    #1;
    total++; if (req !== 1'b0) begin bad++; $display("FAIL midreset_req: got %b want 0", req); end
    total++; if (sel !== '0) begin bad++; $display("FAIL midreset_sel: got %b want 0", sel); end
    total++; if (link !== '0) begin bad++; $display("FAIL midreset_link: got %h want 0", link); end
    model_reset();
    @(posedge clk); #1;
    cyc = 0;
    rst = 1;
    @(posedge clk); #1;
    send_msg(2, 32'h0BAD_0000, 0);
    drain();
  endtask

  task automatic test_single_beat();
    send_msg(1, 32'hA5A5_0001, 0);
    total++; if (req !== 1'b1) begin bad++; $display("FAIL single_req: got %b want 1", req); end
    total++; if (sel !== 5'b00001) begin bad++; $display("FAIL single_sel: got %b want 00001", sel); end
    total++; if (link !== 160'hA5A5_0001) begin bad++; $display("FAIL single_link: got %h want a5a50001", link); end
    do_cycle(0, 0, 0, '0, 1);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL single_pop: got %b want 0", req); end
  endtask

  task automatic test_long_burst();
    send_msg(5, 32'h10, 0);
    total++; if (sel !== 5'b11111) begin bad++; $display("FAIL burst_sel: got %b want 11111", sel); end
    for (int i = 0; i < MAXP; i++) begin
      total++;
      if (link[i*FW +: FW] !== 32'h10 + i)
        begin bad++; $display("FAIL burst_flit%0d: got %h want %h", i, link[i*FW +: FW], 32'h10 + i); end
    end
    drain();
  endtask

  task automatic test_overlength();
    send_msg(6, 32'h20, 0);
    total++; if (req !== 1'b0) begin bad++; $display("FAIL over_req: got %b want 0", req); end
    send_msg(2, 32'h30, 0);
    total++; if (sel !== 5'b00011) begin bad++; $display("FAIL over_next_sel: got %b want 00011", sel); end
    drain();
  endtask

  task automatic test_full();
    for (int k = 0; k < QW; k++) send_msg(k + 1, 32'h100 * k, 0);
    do_cycle(1, 1, 1, 32'h999, 0);   // full: expect retry
    do_cycle(0, 0, 0, '0, 1);        // single grant frees one slot
    send_msg(1, 32'h777, 0);
    drain();
  endtask

  task automatic test_read_err();
    do_cycle(1, 1, 0, 32'h5, 0);
    do_cycle(0, 0, 0, '0, 0);
    send_msg(3, 32'h40, 0);
    do_cycle(1, 1, 0, 32'h6, 0);
    do_cycle(0, 0, 0, '0, 0);
    drain();
  endtask

  task automatic test_back_to_back();
    send_msg(2, 32'h50, 0);
    send_msg(3, 32'h60, 0);
    send_msg(4, 32'h70, 1);          // commit and pop in the same cycle
    drain();
  endtask

  task automatic test_random();
    for (int m = 0; m < 40; m++) begin
      int n;
      if ($urandom_range(0, 9) == 0) begin
        do_cycle(1, 0, 1, $urandom, $urandom_range(0, 1));   // CYC without STB
        do_cycle(0, 0, 0, '0, $urandom_range(0, 1));
        continue;
      end
      n = $urandom_range(1, 6);
      for (int b = 0; b < n; b++) begin
        while ($urandom_range(0, 3) == 0) do_cycle(1, 0, 1, $urandom, $urandom_range(0, 1));
        do_cycle(1, 1, ($urandom_range(0, 15) != 0), $urandom, $urandom_range(0, 1));
      end
      do_cycle(0, 0, 0, '0, $urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) do_cycle(0, 0, 0, '0, $urandom_range(0, 1));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_long_burst();
    test_overlength();
    test_full();
    test_read_err();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
